packet_encoder: RTL
===================

PACKET_ENCODER -- requirements
Module: packet_encoder

Interface
REQ-001 SHALL have parameter TTL, default 64, meaning the IPv4 time-to-live byte.
REQ-002 SHALL have: aclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have: aresetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: s_axis_packet_tdata/tstrb/tvalid/tlast/tready  in/in/in/in/out  32/4/1/1/1  UDP payload stream; tstrb = byte keep, contiguous from LSB.
REQ-005 SHALL have: dest_addr, src_addr  in  48 each  MAC addresses; ip_dest_addr, ip_src_addr  in  32 each; udp_dest_port, udp_src_port  in  16 each; payload_len  in  16  payload bytes, >=1.
REQ-006 SHALL have: m_axis_txc_tdata/tstrb/tvalid/tlast/tready  out/out/out/out/in  32/4/1/1/1  Ethernet TX control stream.
REQ-007 SHALL have: m_axis_txd_tdata/tstrb/tvalid/tlast/tready  out/out/out/out/in  32/4/1/1/1  Ethernet TX data stream.
REQ-008 SHALL have: frames_sent  out  32  count of completed frames.

Function
REQ-009 SHALL implement states IDLE, TXC, HDR, PAY, TAIL.
REQ-010 IDLE: on s_axis_packet_tvalid=1, SHALL latch all header inputs and payload_len, then go to TXC; no payload beat is consumed in IDLE.
REQ-011 TXC: SHALL send 6 words on m_axis_txc: word0 = 0xA000_0000, words1-5 = 0; tstrb = 0xF; tlast on word5; advance only on tvalid&tready; then HDR.
REQ-012 IPv4 checksum SHALL be computed and registered during TXC: ones-complement sum of 16-bit words 0x4500, total_len, ident, 0x4000, {TTL,8'h11}, 0x0000, ip_src hi/lo, ip_dst hi/lo; fold carries twice; invert.
REQ-013 total_len SHALL be payload_len+28 (16-bit, wraps); UDP length SHALL be payload_len+8; UDP checksum SHALL be 0x0000.
REQ-014 ident SHALL be a 16-bit counter, reset 0, incremented when a frame's final txd beat is accepted, wrapping 0xFFFF->0.
REQ-015 Header byte order SHALL be network order: dest MAC (byte0 = dest_addr[47:40]), src MAC, ethertype 0x0800, IPv4 header (DF set, fragment offset 0, protocol 17), UDP header; header byte n SHALL go in txd word n/4, lane n%4 (lane0 = tdata[7:0]).
REQ-016 HDR: SHALL send header bytes 0-39 as 10 words, tstrb 0xF, tlast 0; then PAY with a 16-bit residue register holding header bytes 40-41 (0x0000).
REQ-017 PAY: m_axis_txd_tvalid SHALL equal s_axis_packet_tvalid; s_axis_packet_tready SHALL equal m_axis_txd_tready; output word = {in[15:0], residue}; residue <= in[31:16] on each transfer.
REQ-018 On the input tlast beat with k valid bytes: k<=2 -> output tstrb covers 2+k bytes, tlast=1, go IDLE; k>2 -> output tstrb 0xF, tlast=0, go TAIL.
REQ-019 TAIL: SHALL send one word with residue bytes in lanes 0..k-3, tstrb covering k-2 bytes, tlast=1, s_axis_packet_tready=0; then IDLE.
REQ-020 No tvalid SHALL depend combinationally on its own tready; data SHALL remain stable while tvalid=1 and tready=0.
REQ-021 frames_sent SHALL increment (wrapping) with ident; payload_len vs actual beat count is not checked.

Reset
REQ-022 aresetn=0 SHALL immediately force IDLE, all tvalid=0, s_axis_packet_tready=0, tlast=0, tdata=0, tstrb=0, ident=0, frames_sent=0, residue=0.
REQ-023 Reset mid-frame SHALL abandon the frame without emitting tlast; first frame after release SHALL start with txc word0.

Verification
REQ-024 payload_len=4, one beat 0x44332211 tstrb 0xF, ip src 0xC0A80001, dst 0xC0A80002, TTL 64 -> txc 6 words (tlast on 6th); IP checksum 0xB979; txd word10 = 0x22110000 tstrb 0xF tlast 0, word11 = 0x00004433 tstrb 0x3 tlast 1.
REQ-025 dest_addr 0x0A0B0C0D0E0F -> txd word0 = 0x0D0C0B0A; word1[15:0] = 0x0F0E.
REQ-026 payload_len=2, one beat tstrb 0x3 -> txd word10 tstrb 0xF tlast 1, no TAIL word; 11 txd words total.
REQ-027 m_axis_txd_tready toggled randomly during HDR/PAY -> output identical to no-stall run, no beat lost or duplicated.
REQ-028 Send 3 frames -> ident values 0,1,2 in header, frames_sent=3; reset asserted during PAY of frame 2 -> all tvalid 0 same cycle, frames_sent=0, next frame ident 0.

Source files
------------

// File: rtl/packet_encoder.sv
// rtl/packet_encoder.sv - UDP/IPv4/Ethernet frame encoder emitting TX control and data streams.
module packet_encoder #(
    parameter int TTL = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_packet_tdata,
    input  logic [3:0]  s_axis_packet_tstrb,
    input  logic        s_axis_packet_tvalid,
    input  logic        s_axis_packet_tlast,
    output logic        s_axis_packet_tready,
    input  logic [47:0] dest_addr,
    input  logic [47:0] src_addr,
    input  logic [31:0] ip_dest_addr,
    input  logic [31:0] ip_src_addr,
    input  logic [15:0] udp_dest_port,
    input  logic [15:0] udp_src_port,
    input  logic [15:0] payload_len,
    output logic [31:0] m_axis_txc_tdata,
    output logic [3:0]  m_axis_txc_tstrb,
    output logic        m_axis_txc_tvalid,
    output logic        m_axis_txc_tlast,
    input  logic        m_axis_txc_tready,
    output logic [31:0] m_axis_txd_tdata,
    output logic [3:0]  m_axis_txd_tstrb,
    output logic        m_axis_txd_tvalid,
    output logic        m_axis_txd_tlast,
    input  logic        m_axis_txd_tready,
    output logic [31:0] frames_sent
);

    typedef enum logic [2:0] {IDLE, TXC, HDR, PAY, TAIL} state_t;

    localparam logic [7:0] TTL_BYTE = 8'(TTL);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [15:0] residue;
    logic [3:0]  tail_strb;
    logic [15:0] ident;
    logic [15:0] csum;

    logic [47:0] dst_q, src_q;
    logic [31:0] ipd_q, ips_q;
    logic [15:0] dport_q, sport_q, len_q;

    logic [15:0]  total_len, udp_len;
    logic [19:0]  csum_sum;
    logic [16:0]  fold1, fold2;
    logic [15:0]  csum_next;
    logic [319:0] hdr_be;
    logic [8:0]   hdr_base;
    logic [31:0]  hdr_chunk;
    logic         txc_fire, txd_fire, frame_done;

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    assign total_len = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;

    always_comb begin
        csum_sum = 20'h04500 + {4'h0, total_len} + {4'h0, ident} + 20'h04000
                 + {4'h0, TTL_BYTE, 8'h11}
                 + {4'h0, ips_q[31:16]} + {4'h0, ips_q[15:0]}
                 + {4'h0, ipd_q[31:16]} + {4'h0, ipd_q[15:0]};
        fold1     = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
        fold2     = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
        csum_next = ~fold2[15:0];
    end

    // Header held big-endian (byte 0 at MSB); each word is byte-swapped so byte 4c lands in lane 0.
    assign hdr_be = {dst_q, src_q, 16'h0800, 16'h4500, total_len, ident, 16'h4000,
                     TTL_BYTE, 8'h11, csum, ips_q, ipd_q, sport_q, dport_q, udp_len};
    assign hdr_base  = {4'd9 - cnt, 5'b00000};
    assign hdr_chunk = hdr_be[hdr_base +: 32];

    assign txc_fire   = m_axis_txc_tvalid & m_axis_txc_tready;
    assign txd_fire   = m_axis_txd_tvalid & m_axis_txd_tready;
    assign frame_done = txd_fire & m_axis_txd_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        s_axis_packet_tready = 1'b0;
        m_axis_txc_tdata     = 32'h0;
        m_axis_txc_tstrb     = 4'h0;
        m_axis_txc_tvalid    = 1'b0;
        m_axis_txc_tlast     = 1'b0;
        m_axis_txd_tdata     = 32'h0;
        m_axis_txd_tstrb     = 4'h0;
        m_axis_txd_tvalid    = 1'b0;
        m_axis_txd_tlast     = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_packet_tvalid) state_next = TXC;
            end
            TXC: begin
                m_axis_txc_tvalid = 1'b1;
                m_axis_txc_tdata  = (cnt == 4'd0) ? 32'hA000_0000 : 32'h0;
                m_axis_txc_tstrb  = 4'hF;
                m_axis_txc_tlast  = (cnt == 4'd5);
                if (m_axis_txc_tready && cnt == 4'd5) state_next = HDR;
            end
            HDR: begin
                m_axis_txd_tvalid = 1'b1;
                m_axis_txd_tdata  = {hdr_chunk[7:0], hdr_chunk[15:8], hdr_chunk[23:16], hdr_chunk[31:24]};
                m_axis_txd_tstrb  = 4'hF;
                if (m_axis_txd_tready && cnt == 4'd9) state_next = PAY;
            end
            PAY: begin
                m_axis_txd_tvalid    = s_axis_packet_tvalid;
                s_axis_packet_tready = m_axis_txd_tready;
                // With contiguous keep, k<=2 exactly when lane 2 is empty.
                if (s_axis_packet_tlast && !s_axis_packet_tstrb[2]) begin
                    m_axis_txd_tstrb = {s_axis_packet_tstrb[1:0], 2'b11};
                    m_axis_txd_tlast = 1'b1;
                end else begin
                    m_axis_txd_tstrb = 4'hF;
                end
                m_axis_txd_tdata = {s_axis_packet_tdata[15:0], residue} & lane_mask(m_axis_txd_tstrb);
                if (s_axis_packet_tvalid && m_axis_txd_tready && s_axis_packet_tlast) begin
                    state_next = s_axis_packet_tstrb[2] ? TAIL : IDLE;
                end
            end
            TAIL: begin
                m_axis_txd_tvalid = 1'b1;
                m_axis_txd_tstrb  = tail_strb;
                m_axis_txd_tlast  = 1'b1;
                m_axis_txd_tdata  = {16'h0, residue} & lane_mask(tail_strb);
                if (m_axis_txd_tready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt         <= 4'd0;
            residue     <= 16'h0;
            tail_strb   <= 4'h0;
            ident       <= 16'h0;
            frames_sent <= 32'h0;
            csum        <= 16'h0;
            dst_q       <= 48'h0;
            src_q       <= 48'h0;
            ipd_q       <= 32'h0;
            ips_q       <= 32'h0;
            dport_q     <= 16'h0;
            sport_q     <= 16'h0;
            len_q       <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (s_axis_packet_tvalid) begin
                        dst_q   <= dest_addr;
                        src_q   <= src_addr;
                        ipd_q   <= ip_dest_addr;
                        ips_q   <= ip_src_addr;
                        dport_q <= udp_dest_port;
                        sport_q <= udp_src_port;
                        len_q   <= payload_len;
                    end
                end
                TXC: begin
                    csum <= csum_next;
                    if (txc_fire) cnt <= (cnt == 4'd5) ? 4'd0 : cnt + 4'd1;
                end
                HDR: begin
                    if (txd_fire) begin
                        cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
                        if (cnt == 4'd9) residue <= 16'h0;
                    end
                end
                PAY: begin
                    if (txd_fire) begin
                        residue <= s_axis_packet_tdata[31:16];
                        if (s_axis_packet_tlast && s_axis_packet_tstrb[2]) begin
                            tail_strb <= {2'b00, s_axis_packet_tstrb[3:2]};
                        end
                    end
                end
                default: ;
            endcase
            if (frame_done) begin
                ident       <= ident + 16'd1;
                frames_sent <= frames_sent + 32'd1;
            end
        end
    end

endmodule
